// File: rtl/flat_to_column_stream.sv
// flat_to_column_stream: captures a packed vector of COLS elements over a
// valid/ready handshake and replays it one column per beat, with a registered
// unpacked view of the captured vector.
// Column i lives at bits [i*BIT_WIDTH +: BIT_WIDTH] of in_i.
// Optional build macro COLUMN_STREAM_REVERSE_EN: emit beats highest column
// first (out_col_o still reports the true column, last beat is column 0).
module flat_to_column_stream #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned COLS      = 8,
  localparam int unsigned CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [COLS*BIT_WIDTH-1:0] in_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [BIT_WIDTH-1:0]      out_o,
  output logic [CW-1:0]             out_col_o,
  output logic                      out_last_o,
  output logic [BIT_WIDTH-1:0]      out_array_o [COLS]
);

`ifdef COLUMN_STREAM_REVERSE_EN
  localparam logic [CW-1:0] ColStart = CW'(COLS - 1);
  localparam logic [CW-1:0] ColLast  = '0;
`else
  localparam logic [CW-1:0] ColStart = '0;
  localparam logic [CW-1:0] ColLast  = CW'(COLS - 1);
`endif

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                     state_q, state_d;
  logic [COLS*BIT_WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic at_last;
  logic beat;
  logic capture;

  assign at_last = (cnt_q == ColLast);
  assign beat    = (state_q == StStream) && out_ready_i;
  // in_ready_o already folds in the last-beat pass-through case.
  assign capture = in_valid_i && in_ready_o;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a last beat with a waiting vector stays in StStream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (capture) state_d = StStream;
      end
      StStream: begin
        if (beat && at_last) state_d = capture ? StStream : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; out_o is always the held element at the current column.
  always_comb begin
    out_valid_o = (state_q == StStream);
    in_ready_o  = (state_q == StIdle) || (beat && at_last);
    out_last_o  = out_valid_o && at_last;
    out_col_o   = cnt_q;
    out_o       = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (cnt_q == CW'(i)) out_o = data_q[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Holding register and column counter next-state.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (capture) begin
      data_d = in_i;
      cnt_d  = ColStart;
    end else if (beat && !at_last) begin
`ifdef COLUMN_STREAM_REVERSE_EN
      cnt_d = cnt_q - CW'(1);
`else
      cnt_d = cnt_q + CW'(1);
`endif
    end
  end

  // Datapath registers; counter holds on the final beat so it never leaves
  // the 0..COLS-1 range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Unpacked view of the holding register, updated only on capture.
  always_comb begin
    for (int i = 0; i < int'(COLS); i++) begin
      out_array_o[i] = data_q[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

endmodule

// File: doc/flat_to_column_stream.md
Name: flat_to_column_stream

Overview:
- Accepts a flat packed vector of COLS elements over a valid/ready handshake and emits it one column per beat.
- The packed layout is column 0 in bits [BIT_WIDTH-1:0], column 1 next above it, and so on.
- Also presents a registered unpacked copy of the captured vector.
- Receiving end of the array packing path: turns bus-width words back into per-column element traffic for downstream column processors.

Parameters:
BIT_WIDTH, 4, width of one element/column in bits (>=1)
COLS, 8, number of columns per packed vector (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  packed vector on `in` is valid
in_ready  output  1  block can accept a vector this cycle
in  input  COLS*BIT_WIDTH  packed vector; column i at bits [i*BIT_WIDTH +: BIT_WIDTH]
out_valid  output  1  `out` holds a valid column beat
out_ready  input  1  downstream accepts the beat
out  output  BIT_WIDTH  current column element
out_col  output  CW  index of current column; CW = max(1, $clog2(COLS))
out_last  output  1  high on the final beat of a vector
out_array  output  BIT_WIDTH x [COLS] (unpacked)  registered copy of the captured vector; element i = column i

Behaviour:
- Reset (rst=1 at clock edge, dominates all other inputs):
  - state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_col=0, out_last=0, out=0, out_array all zero.
- States:
  - IDLE: no vector held.
  - STREAM: vector held; beats pending.
- Capture:
  - in_valid & in_ready at edge N registers `in` into the holding register and out_array, sets counter=0, enters STREAM.
  - out_valid=1 with column 0 from cycle N+1; one-cycle latency.
- Beat transfer: out_valid & out_ready.
  - Non-last beat: counter increments by 1.
  - Last beat: counter reaches COLS-1.
- Stall: while out_valid=1 and out_ready=0, out, out_col and out_last hold stable. in_ready=0 unless the pass-through rule below applies.
- out is always the element of the holding register at out_col.
- out_last = (out_col == COLS-1) & out_valid.
- Last beat transfer:
  - If in_valid=1 the same cycle, the new vector is captured, counter returns to 0, and the state stays STREAM. Back-to-back vectors produce no bubble.
  - Otherwise the state returns to IDLE and out_valid drops the next cycle.
- in_ready = IDLE | (STREAM & out_valid & out_ready & out_last). It depends combinationally on out_ready only in the last-beat case.
- out_array updates only on capture and holds until the next capture or reset; it remains valid after return to IDLE.
- COLS=1: every beat is last; out_col is the constant 0 (CW=1); sustained throughput of one vector per cycle.
- COLS not a power of two: the counter never exceeds COLS-1; no wrap through unused codes.
- rst asserted mid-vector: the remaining beats are discarded; no further beats of that vector appear after reset release.
- in_valid while in_ready=0 is ignored; the upstream holds per handshake rules. The block does not check this.

Optional Feature:
- Macro COLUMN_STREAM_REVERSE_EN.
- Defined: beats are emitted highest column first. Counter starts at COLS-1 and decrements; out_col reports the true column index; out_last = (out_col == 0). out_array layout is unchanged.
- Undefined: ascending order as specified above.

Test Plan:
- Basic stream: BIT_WIDTH=4, COLS=8. Apply in=32'h7654_3210 with out_ready=1 -> beats out=0..7 on 8 consecutive cycles starting one cycle after capture; out_col=0..7; out_last only with out=7. out_array[i]=i.
- Back-to-back: present 32'hFEDC_BA98 with in_valid held across the last beat of the first vector -> captured on the out_last cycle; out=8 follows out=7 with no gap; 16 beats in 16 cycles.
- Backpressure: drop out_ready for 3 cycles at out_col=3 -> out=3, out_col=3 held stable; in_ready=0 throughout; resumes at 4 when out_ready returns.
- Reset mid-vector: assert rst at out_col=5 -> next cycle out_valid=0, out_col=0, out_array zero, in_ready=1; no beat 6/7 afterwards.
- Edge parameters: COLS=1, BIT_WIDTH=8 with continuous in_valid/out_ready, inputs 8'hA5, 8'h3C -> one beat per cycle, out_last=1 always. COLS=5: out_col sequence 0..4, then back to 0 only on a new capture.
- With COLUMN_STREAM_REVERSE_EN defined, COLS=8, in=32'h7654_3210 -> out=7..0; out_last on out=0.
